// File: rtl/flp_round_pack.sv
`default_nettype none
// ============================================================================
// flp_round_pack : round, renormalize, saturate and pack a normalized
//                  significand through a 2-stage valid/ready pipeline.
//                  Define FLP_ROUND_RNE_EN for round-to-nearest-even,
//                  otherwise the stage truncates (round toward zero).
// Revision       : 1.0
// ============================================================================
module flp_round_pack #(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_sign,
  input  logic                      i_zero,
  input  logic [EWIDTH+1:0]         i_ex,
  input  logic [EWIDTH+1:0]         i_exd,
  input  logic [SWIDTH+RSWIDTH:0]   i_nsg,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [EWIDTH+SWIDTH:0]    o_res,
  output logic                      o_ovf,
  output logic                      o_unf
);

  localparam int OUTW = 1 + SWIDTH + RSWIDTH;
  localparam int RESW = 1 + EWIDTH + SWIDTH;

  logic                 adv2;
  logic                 s1_valid_q;
  logic                 sign1_q;
  logic                 zero1_q;
  logic [EWIDTH+1:0]    e1_q;
  logic [SWIDTH+1:0]    m1_q;
  logic                 out_valid_q;
  logic [RESW-1:0]      res_q;
  logic                 ovf_q;
  logic                 unf_q;

  logic [EWIDTH+1:0]    e1_d;
  logic [SWIDTH+1:0]    m1_d;
  logic                 inc;

  logic                 carry;
  logic [EWIDTH+1:0]    e2;
  logic [SWIDTH-1:0]    frac;
  logic                 e2_ovf;
  logic                 e2_unf;
  logic [RESW-1:0]      res_d;
  logic                 ovf_d;
  logic                 unf_d;

  assign adv2    = ~out_valid_q | i_ready;
  assign o_ready = ~s1_valid_q | adv2;
  assign o_valid = out_valid_q;
  assign o_res   = res_q;
  assign o_ovf   = ovf_q;
  assign o_unf   = unf_q;

  assign e1_d = i_ex + i_exd;

`ifdef FLP_ROUND_RNE_EN
  logic lsb;
  logic g;
  logic s;
  assign lsb = i_nsg[RSWIDTH];
  assign g   = i_nsg[RSWIDTH-1];
  assign s   = |i_nsg[RSWIDTH-2:0];
  assign inc = g & (s | lsb);
`else
  logic [RSWIDTH-1:0] unused_rnd_bits;
  assign unused_rnd_bits = i_nsg[RSWIDTH-1:0];
  assign inc = 1'b0;
`endif

  assign m1_d = {1'b0, i_nsg[OUTW-1:RSWIDTH]} + {{(SWIDTH+1){1'b0}}, inc};

  // The hidden bit is implied by the packed format and never stored.
  logic unused_hidden;
  assign unused_hidden = m1_q[SWIDTH];

  always_comb begin
    carry  = m1_q[SWIDTH+1];
    e2     = e1_q + {{(EWIDTH+1){1'b0}}, carry};
    frac   = carry ? '0 : m1_q[SWIDTH-1:0];
    // e2 >= 2^EWIDTH-1 as a non-negative value; e2 <= 0 as signed.
    e2_ovf = ~e2[EWIDTH+1] & (e2[EWIDTH] | (&e2[EWIDTH-1:0]));
    e2_unf = e2[EWIDTH+1] | (e2 == '0);
    res_d  = {sign1_q, e2[EWIDTH-1:0], frac};
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (zero1_q) begin
      res_d = {sign1_q, {(RESW-1){1'b0}}};
    end else if (e2_ovf) begin
      res_d = {sign1_q, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
      ovf_d = 1'b1;
    end else if (e2_unf) begin
      res_d = {sign1_q, {(RESW-1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (o_ready) s1_valid_q <= i_valid;
      if (adv2) out_valid_q <= s1_valid_q;
      if (adv2 && s1_valid_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (o_ready && i_valid) begin
      sign1_q <= i_sign;
      zero1_q <= i_zero;
      e1_q    <= e1_d;
      m1_q    <= m1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flp_round_pack.sv
`default_nettype none
// Directed bench for flp_round_pack: literal vectors plus an arithmetic
// reference model checked on every output transfer.
module tb_flp_round_pack;
  localparam int EW = 8;
  localparam int SW = 23;
  localparam int RW = 2;
  localparam int NW = 1 + SW + RW;
  localparam int OW = 1 + EW + SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic          i_sign;
  logic          i_zero;
  logic [EW+1:0] i_ex;
  logic [EW+1:0] i_exd;
  logic [NW-1:0] i_nsg;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_res;
  logic          o_ovf;
  logic          o_unf;

  flp_round_pack dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_zero(i_zero), .i_ex(i_ex), .i_exd(i_exd),
    .i_nsg(i_nsg), .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res),
    .o_ovf(o_ovf), .o_unf(o_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] res;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_acc    = 0;
  logic stall_prev = 1'b0;
  exp_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference: integer rounding of the whole significand, then classify.
  function automatic exp_t model(input logic sg, input logic z, input logic [EW+1:0] ex,
                                 input logic [EW+1:0] exd, input logic [NW-1:0] nsg);
    exp_t   r;
    longint e, mant, rem, half;
    r = '0;
    if (z) begin
      r.res = {sg, {(OW-1){1'b0}}};
      return r;
    end
    e    = longint'($signed(ex)) + longint'($signed(exd));
    mant = longint'(nsg) >> RW;
    rem  = longint'(nsg) % (longint'(1) << RW);
    half = longint'(1) << (RW - 1);
`ifdef FLP_ROUND_RNE_EN
    if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
`endif
    if (mant == (longint'(1) << (SW + 1))) begin
      mant = mant / 2;
      e++;
    end
    if (e >= (longint'(1) << EW) - 1) begin
      r.res = {sg, {EW{1'b1}}, {SW{1'b0}}};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.res = {sg, {(OW-1){1'b0}}};
      r.unf = 1'b1;
    end else begin
      r.res = {sg, e[EW-1:0], mant[SW-1:0]};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("hold", {o_valid, o_res, o_ovf, o_unf}, {1'b1, held});
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_out: got o_res=%h, expected no result", o_res);
        end else begin
          check("model", {o_res, o_ovf, o_unf}, q.pop_front());
        end
      end
      if (i_valid && o_ready) begin
        q.push_back(model(i_sign, i_zero, i_ex, i_exd, i_nsg));
        n_acc++;
      end
      stall_prev = o_valid && !i_ready;
      held       = {o_res, o_ovf, o_unf};
    end
  end

  task automatic drive(input logic sg, input logic z, input logic [EW+1:0] ex,
                       input logic [EW+1:0] exd, input logic [NW-1:0] nsg);
    int t = 0;
    i_valid = 1'b1; i_sign = sg; i_zero = z; i_ex = ex; i_exd = exd; i_nsg = nsg;
    @(negedge clk);
    while (!o_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: got o_ready=0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string name, input logic sg, input logic z,
                        input logic [EW+1:0] ex, input logic [EW+1:0] exd,
                        input logic [NW-1:0] nsg, input logic [OW-1:0] xres,
                        input logic xovf, input logic xunf);
    i_ready = 1'b1;
    drive(sg, z, ex, exd, nsg);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(name, {o_valid, o_res, o_ovf, o_unf}, {1'b1, xres, xovf, xunf});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc0;
    int   t;
    logic stale;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_sign = 1'b0; i_zero = 1'b0;
    i_ex = '0; i_exd = '0; i_nsg = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {o_valid, o_res, o_ovf, o_unf, o_ready}, {1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;

    single("one",      1'b0, 1'b0, 10'd127, 10'd0, 26'h2000000, 32'h3F800000, 1'b0, 1'b0);
    single("tie_even", 1'b0, 1'b0, 10'd127, 10'd0, 26'h2000002, 32'h3F800000, 1'b0, 1'b0);
`ifdef FLP_ROUND_RNE_EN
    single("tie_odd",  1'b0, 1'b0, 10'd127, 10'd0, 26'h2000006, 32'h3F800002, 1'b0, 1'b0);
    single("carry",    1'b0, 1'b0, 10'd127, 10'd0, 26'h3FFFFFE, 32'h40000000, 1'b0, 1'b0);
    single("ovf_rnd",  1'b0, 1'b0, 10'd254, 10'd0, 26'h3FFFFFE, 32'h7F800000, 1'b1, 1'b0);
`else
    single("tie_odd",  1'b0, 1'b0, 10'd127, 10'd0, 26'h2000006, 32'h3F800001, 1'b0, 1'b0);
    single("carry",    1'b0, 1'b0, 10'd127, 10'd0, 26'h3FFFFFE, 32'h3FFFFFFF, 1'b0, 1'b0);
    single("ovf_rnd",  1'b0, 1'b0, 10'd254, 10'd0, 26'h3FFFFFE, 32'h7F7FFFFF, 1'b0, 1'b0);
`endif
    single("max_norm", 1'b0, 1'b0, 10'd254, 10'd0, 26'h2000000, 32'h7F000000, 1'b0, 1'b0);
    single("ovf_exp",  1'b1, 1'b0, 10'd250, 10'd5, 26'h2000000, 32'hFF800000, 1'b1, 1'b0);
    single("unf",      1'b1, 1'b0, 10'd1, 10'h3FF, 26'h2000000, 32'h80000000, 1'b0, 1'b1);
    single("min_norm", 1'b0, 1'b0, 10'd2, 10'h3FF, 26'h2000004, 32'h00800001, 1'b0, 1'b0);
    single("zero",     1'b1, 1'b1, 10'd300, 10'd7, 26'h3FFFFFF, 32'h80000000, 1'b0, 1'b0);

    // Backpressure: four operands while the consumer stalls.
    i_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int k = 0; k < 4; k++)
          drive(k[0], 1'b0, 10'(100 + k), 10'(k), 26'h2000000 | 26'(k * 5 + 1));
        i_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_oready", o_ready, 0);
        check("bp_accepts", n_acc - acc0, 2);
        repeat (2) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join

    // Continuous input with i_ready toggling every cycle.
    fork
      begin
        for (int k = 0; k < 8; k++)
          drive(k[1], 1'b0, 10'(120 + k), 10'(3 - k), 26'h2000000 | 26'(k * 37 + 5));
        i_valid = 1'b0;
      end
      begin
        repeat (24) begin
          @(posedge clk);
          #1 i_ready = ~i_ready;
        end
        i_ready = 1'b1;
      end
    join

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain", q.size(), 0);

    // Reset with both stages full and stalled.
    @(posedge clk);
    #1 i_ready = 1'b0;
    drive(1'b0, 1'b0, 10'd130, 10'd0, 26'h2000010);
    drive(1'b1, 1'b0, 10'd131, 10'd0, 26'h2000020);
    i_nsg = 26'h2000030;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_ovalid", o_valid, 0);
    check("rst_mid_oready", o_ready, 1);
    i_ready = 1'b1;
    stale = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_valid) stale = 1'b1;
    end
    check("rst_no_stale", stale, 0);

    single("post_rst", 1'b0, 1'b0, 10'd128, 10'd0, 26'h2000000, 32'h40000000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/flp_round_pack.md
# flp_round_pack

Rounding and packing stage for the floating-point datapath; sits directly downstream of the significand normalizer and consumes its normalized significand and exponent delta. Adds the delta to the pre-normalization exponent, rounds, renormalizes on carry-out, saturates overflow to infinity and flushes underflow to zero. Emits an IEEE-754-style packed word through a 2-stage valid/ready pipeline.

## Interface
- `EWIDTH`, 8: exponent width.
- `SWIDTH`, 23: stored fraction width.
- `RSWIDTH`, 2: reserved rounding bits below the fraction (guard, then jammed sticky), ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `i_valid`  in  1  input operand valid.
- `o_ready`  out  1  stage can accept an input this cycle.
- `i_sign`  in  1  result sign.
- `i_zero`  in  1  result is exactly zero; other operand fields are ignored.
- `i_ex`  in  EWIDTH+2  biased exponent before normalization, two's complement.
- `i_exd`  in  EWIDTH+2  normalizer exponent delta, two's complement.
- `i_nsg`  in  1+SWIDTH+RSWIDTH  normalized significand, MSB is the hidden 1.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts result.
- `o_res`  out  1+EWIDTH+SWIDTH  packed {sign, exponent, fraction}.
- `o_ovf`  out  1  result overflowed to infinity.
- `o_unf`  out  1  result underflowed to zero.

## Operation
- Stage 1 (S1), on accept: `e1 = i_ex + i_exd` (EWIDTH+2 bits, wrap ignored); `lsb = i_nsg[RSWIDTH]`, `g = i_nsg[RSWIDTH-1]`, `s = |i_nsg[RSWIDTH-2:0]`; `inc` per rounding mode (see Configuration); `m1 = {1'b0, i_nsg[OUTW-1:RSWIDTH]} + inc` (SWIDTH+2 bits). Register sign, zero, e1, m1.
- Stage 2 (S2): if `m1[SWIDTH+1]`, frac = 0 and `e2 = e1 + 1`; else frac = `m1[SWIDTH-1:0]`, `e2 = e1`.
- Classification, priority order:
  - zero flag set: `o_res = {sign, 0, 0}`, flags 0.
  - `e2` signed ≥ 2^EWIDTH−1: `o_res = {sign, all-ones, 0}`, `o_ovf = 1`.
  - `e2` signed ≤ 0: `o_res = {sign, 0, 0}`, `o_unf = 1`. No denormals are produced.
  - otherwise: `o_res = {sign, e2[EWIDTH-1:0], frac}`.
- Handshake:
  - Input transfer when `i_valid & o_ready`; output transfer when `o_valid & i_ready`.
  - `adv2 = ~o_valid | i_ready`; `o_ready = ~s1_valid | adv2`.
  - S2 loads from S1 when `adv2`. `o_valid` becomes `s1_valid`.
  - S1 loads when `o_ready`. `s1_valid` becomes `i_valid`.
  - Data registers hold while stalled. Outputs remain stable while `o_valid & ~i_ready`.
  - No combinational path from `i_valid` to `o_ready`. The only combinational path is `i_ready` → `o_ready`.
- Simultaneous accept and emit in one cycle sustains one result per cycle.

## Timing
- Latency: an input accepted at edge N appears on `o_valid`/`o_res` after edge N+1, when unstalled.
- Throughput: 1 per cycle.
- Reset (sync): `s1_valid = 0`, `o_valid = 0`, `o_res = 0`, `o_ovf = 0`, `o_unf = 0`. All in-flight data is discarded, including reset asserted mid-stall. `o_ready = 1` in the first cycle after reset.
- Flags are registered with `o_res` and qualified by `o_valid`.

## Configuration
- `FLP_ROUND_RNE_EN` defined: round-to-nearest-even, `inc = g & (s | lsb)`.
- `FLP_ROUND_RNE_EN` undefined: round toward zero, `inc = 0`, so carry-out is never taken. Overflow still saturates to infinity.

## Test plan
All values below use the defaults, with `i_exd` = 0 unless noted.
- 1.0: `i_ex` = 127, `i_nsg` = 26'h2000000 -> `o_res` = 32'h3F800000 one cycle after accept, flags 0.
- Ties, RNE build:
  - `i_nsg` = 26'h2000002 (lsb 0, g 1, s 0) -> 32'h3F800000.
  - `i_nsg` = 26'h2000006 (lsb 1, tie) -> 32'h3F800002.
  - Truncate build gives 32'h3F800001 for the second case.
- Carry-out: `i_ex` = 127, `i_nsg` = 26'h3FFFFFE, RNE -> 32'h40000000.
- Overflow/underflow:
  - `i_ex` = 254, same significand as carry-out, RNE -> 32'h7F800000 with `o_ovf`.
  - `i_ex` = 1, `i_exd` = −1, `i_sign` = 1 -> 32'h80000000 with `o_unf`.
  - `i_zero` = 1 -> signed zero, flags 0.
- Backpressure: stream 4 operands with `i_ready` low for 3 cycles.
  - `o_ready` deasserts after 2 accepts.
  - `o_res` is held stable during the stall.
  - All 4 results arrive in order with no loss or duplication.
  - Then toggle `i_ready` every cycle under continuous input.
- Reset mid-flight: assert `rst` for 1 cycle with both stages full and stalled -> next cycle `o_valid` = 0, `o_ready` = 1. Stale results never appear.
